// File: rtl/dma_pkg.sv
// Shared types and helpers for the 4-channel DMA priority arbiter.
// The rotate helper lets the picker always scan from bit 0.
package dma_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0]        ChannelID_t;
  typedef logic [NUM_CH-1:0] ChMask_t;

  typedef enum logic [1:0] {IDLE, GRANT, SERVICE, GAP} ArbState_t;

  // Result bit k holds channel (base + k) mod NUM_CH.
  function automatic ChMask_t rotate_down(ChMask_t v, ChannelID_t base);
    ChMask_t    r;
    ChannelID_t idx;
    r   = '0;
    idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx  = base + ChannelID_t'(k);
      r[k] = v[idx];
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_prio_pick.sv
// Combinational rotate-and-select: first requesting channel in priority order,
// starting at ptr in rotating mode and at channel 0 in fixed mode.
module dma_prio_pick
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] eff,
  input  ChannelID_t        ptr,
  input  logic              rotating,
  output logic              any,
  output ChannelID_t        winner
);

  ChannelID_t base;
  ChannelID_t offset;
  ChMask_t    rotated;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    base    = rotating ? ptr : '0;
    rotated = rotate_down(eff, base);
    offset  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rotated[k]) offset = ChannelID_t'(k);
    end
    any    = |eff;
    winner = base + offset;
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A-style DMA priority encoder: DREQ synchronizer, request merge, and the
// grant/start/done handshake FSM with rotating-priority pointer and gap timer.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              DREQActiveLow,
  input  logic              RotatingPriority,
  input  logic              ControllerDisable,
  input  logic [NUM_CH-1:0] MaskReg,
  input  logic [NUM_CH-1:0] SoftReq,
  input  logic              MasterClear,
  input  logic              ServiceStart,
  input  logic              ServiceDone,
  output logic              ValidReqID,
  output logic [1:0]        ReqID,
  output logic [NUM_CH-1:0] ReqStatus,
  output logic              Busy
);

  localparam logic [1:0] GAP_LOAD = 2'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  ChMask_t    hw;
  ChMask_t    eff;
  logic       any;
  ChannelID_t winner;

  ArbState_t  state_q;
  ChannelID_t req_id_q;
  ChannelID_t ptr_q;
  ChannelID_t ptr_d;
  logic [1:0] gap_cnt_q;
  logic       valid_q;
  logic       busy_q;
  ChMask_t    status_q;

  // NOTE: polarity is folded in ahead of the chain, so a reset value of 0 is
  // the inactive level in both polarities and no phantom request follows reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync_q[0] <= DREQ ^ {NUM_CH{DREQActiveLow}};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign hw    = sync_q[SYNC_STAGES-1];
  assign eff   = (hw & ~MaskReg) | SoftReq;
  assign ptr_d = req_id_q + 2'd1;

  dma_prio_pick u_pick (
    .eff      (eff),
    .ptr      (ptr_q),
    .rotating (RotatingPriority),
    .any      (any),
    .winner   (winner)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      req_id_q  <= '0;
      ptr_q     <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      status_q  <= '0;
    end else if (MasterClear) begin
      state_q   <= IDLE;
      req_id_q  <= '0;
      ptr_q     <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      status_q  <= '0;
    end else begin
      status_q <= hw | SoftReq;
      unique case (state_q)
        IDLE: begin
          if (any && !ControllerDisable) begin
            req_id_q <= winner;
            valid_q  <= 1'b1;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          // Start outranks a same-cycle withdrawal: TCL has already committed.
          if (ServiceStart) begin
            busy_q  <= 1'b1;
            state_q <= SERVICE;
          end else if (!eff[req_id_q]) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        SERVICE: begin
          if (ServiceDone) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            if (RotatingPriority) ptr_q <= ptr_d;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              gap_cnt_q <= GAP_LOAD;
              state_q   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == 2'd0) state_q   <= IDLE;
          else                   gap_cnt_q <= gap_cnt_q - 2'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ValidReqID = valid_q;
  assign ReqID      = req_id_q;
  assign ReqStatus  = status_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_dma_priority_arbiter;

  localparam int SYNC_STAGES = 2;
  localparam int GAP_CYCLES  = 1;
  localparam int P_IDLE = 0, P_GRANT = 1, P_SERVICE = 2, P_GAP = 3;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       DREQActiveLow, RotatingPriority, ControllerDisable;
  logic [3:0] MaskReg, SoftReq;
  logic       MasterClear, ServiceStart, ServiceDone;
  logic       ValidReqID;
  logic [1:0] ReqID;
  logic [3:0] ReqStatus;
  logic       Busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: phase, granted channel, rotation start, gap cycles left.
  int         m_phase, m_id, m_ptr, m_gap;
  logic [3:0] m_status;
  logic [3:0] hist [SYNC_STAGES];

  dma_priority_arbiter #(.SYNC_STAGES(SYNC_STAGES), .GAP_CYCLES(GAP_CYCLES)) dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .DREQ              (DREQ),
    .DREQActiveLow     (DREQActiveLow),
    .RotatingPriority  (RotatingPriority),
    .ControllerDisable (ControllerDisable),
    .MaskReg           (MaskReg),
    .SoftReq           (SoftReq),
    .MasterClear       (MasterClear),
    .ServiceStart      (ServiceStart),
    .ServiceDone       (ServiceDone),
    .ValidReqID        (ValidReqID),
    .ReqID             (ReqID),
    .ReqStatus         (ReqStatus),
    .Busy              (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] e, input int start);
    for (int k = 0; k < 4; k++) if (e[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_id     = 0;
    m_ptr    = 0;
    m_gap    = 0;
    m_status = '0;
    for (int s = 0; s < SYNC_STAGES; s++) hist[s] = '0;
  endtask

  // One clock of the reference: requests are seen SYNC_STAGES edges late.
  task automatic model_step();
    logic [3:0] hw, eff;
    if (RESET_N !== 1'b1) begin
      model_reset();
      return;
    end
    hw = hist[SYNC_STAGES-1];
    for (int s = SYNC_STAGES - 1; s > 0; s--) hist[s] = hist[s-1];
    hist[0] = DREQ ^ {4{DREQActiveLow}};
    eff = (hw & ~MaskReg) | SoftReq;
    if (MasterClear) begin
      m_phase = P_IDLE; m_id = 0; m_ptr = 0; m_gap = 0; m_status = '0;
      return;
    end
    m_status = hw | SoftReq;
    case (m_phase)
      P_IDLE:
        if (eff != 0 && !ControllerDisable) begin
          m_id    = pick(eff, RotatingPriority ? m_ptr : 0);
          m_phase = P_GRANT;
        end
      P_GRANT:
        if (ServiceStart)    m_phase = P_SERVICE;
        else if (!eff[m_id]) m_phase = P_IDLE;
      P_SERVICE:
        if (ServiceDone) begin
          if (RotatingPriority) m_ptr = (m_id + 1) % 4;
          m_gap   = GAP_CYCLES;
          m_phase = (GAP_CYCLES == 0) ? P_IDLE : P_GAP;
        end
      default: begin
        m_gap = m_gap - 1;
        if (m_gap <= 0) m_phase = P_IDLE;
      end
    endcase
  endtask

  initial forever begin
    @(negedge RESET_N);
    model_reset();
  end

  // Per-cycle comparison against the model, 1 ns after each rising edge.
  initial forever begin
    @(posedge CLK);
    model_step();
    #1;
    check("model valid", ValidReqID, (m_phase == P_GRANT || m_phase == P_SERVICE));
    check("model busy", Busy, (m_phase == P_SERVICE));
    check("model status", ReqStatus, m_status);
    if (m_phase == P_GRANT || m_phase == P_SERVICE) check("model reqid", ReqID, m_id);
  end

  task automatic after_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(input string name, input int budget);
    int n = 0;
    while (ValidReqID !== 1'b1 && n < budget) begin
      after_edge();
      n++;
    end
    check({name, " grant in time"}, ValidReqID, 1);
  endtask

  task automatic serve();
    @(negedge CLK); ServiceStart = 1'b1;
    @(negedge CLK); ServiceStart = 1'b0; ServiceDone = 1'b1;
    @(negedge CLK); ServiceDone  = 1'b0;
  endtask

  task automatic master_clear();
    @(negedge CLK); MasterClear = 1'b1;
    @(negedge CLK); MasterClear = 1'b0;
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    RESET_N = 1'b0; DREQ = '0; DREQActiveLow = 1'b0; RotatingPriority = 1'b0;
    ControllerDisable = 1'b0; MaskReg = '0; SoftReq = '0; MasterClear = 1'b0;
    ServiceStart = 1'b0; ServiceDone = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset valid", ValidReqID, 0);
    check("reset reqid", ReqID, 0);
    check("reset status", ReqStatus, 0);
    check("reset busy", Busy, 0);
    RESET_N = 1'b1;

    // Fixed priority and DREQ-to-grant latency.
    @(negedge CLK); DREQ = 4'b1010;
    after_edge();
    after_edge();
    check("fixed valid before latency", ValidReqID, 0);
    after_edge();
    check("fixed valid at latency", ValidReqID, 1);
    check("fixed first reqid", ReqID, 1);
    check("fixed status", ReqStatus, 4'b1010);
    @(negedge CLK); ServiceStart = 1'b1; DREQ = 4'b1000;
    @(negedge CLK); ServiceStart = 1'b0; ServiceDone = 1'b1;
    @(negedge CLK); ServiceDone = 1'b0;
    wait_grant("fixed second", 10);
    check("fixed second reqid", ReqID, 3);
    DREQ = '0;
    master_clear();
    repeat (4) @(negedge CLK);

    // Rotating priority with all channels requesting.
    RotatingPriority = 1'b1; DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant("rotate", 12);
      check("rotate order", ReqID, exp_order[i]);
      serve();
    end
    DREQ = '0; RotatingPriority = 1'b0;
    master_clear();
    repeat (4) @(negedge CLK);

    // Masked hardware, unmaskable software request, then withdrawal.
    MaskReg = 4'b1111; DREQ = 4'b1111; SoftReq = 4'b0100;
    wait_grant("soft", 8);
    check("soft reqid", ReqID, 2);
    @(negedge CLK); SoftReq = 4'b0000;
    after_edge();
    check("withdraw valid", ValidReqID, 0);
    @(negedge CLK); SoftReq = 4'b0001;
    after_edge();
    check("idle regrant valid", ValidReqID, 1);
    check("idle regrant reqid", ReqID, 0);

    // Start and withdrawal in the same GRANT cycle: start wins.
    @(negedge CLK); ServiceStart = 1'b1; SoftReq = 4'b0000;
    after_edge();
    check("start beats withdraw busy", Busy, 1);
    check("start beats withdraw valid", ValidReqID, 1);
    @(negedge CLK); ServiceStart = 1'b0; ServiceDone = 1'b1;
    @(negedge CLK); ServiceDone = 1'b0; MaskReg = '0; DREQ = '0;
    repeat (5) @(negedge CLK);
    ServiceDone = 1'b1; ServiceStart = 1'b1;
    after_edge();
    check("done in idle valid", ValidReqID, 0);
    check("done in idle busy", Busy, 0);
    @(negedge CLK); ServiceDone = 1'b0; ServiceStart = 1'b0;

    // Active-low DREQ and ControllerDisable.
    RESET_N = 1'b0; DREQActiveLow = 1'b1; DREQ = 4'b1111;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("active low idle valid", ValidReqID, 0);
    check("active low idle status", ReqStatus, 0);
    DREQ = 4'b1110;
    wait_grant("active low", 8);
    check("active low reqid", ReqID, 0);
    check("active low status", ReqStatus, 4'b0001);
    @(negedge CLK); ControllerDisable = 1'b1; MasterClear = 1'b1;
    @(negedge CLK); MasterClear = 1'b0;
    repeat (3) @(negedge CLK);
    check("disabled valid", ValidReqID, 0);
    check("disabled status", ReqStatus, 4'b0001);
    RESET_N = 1'b0; DREQActiveLow = 1'b0; DREQ = '0; ControllerDisable = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    // MasterClear mid-service with pointer at 3.
    RotatingPriority = 1'b1; DREQ = 4'b0100;
    wait_grant("ptr setup", 8);
    check("ptr setup reqid", ReqID, 2);
    serve();
    wait_grant("ptr three", 8);
    check("ptr three reqid", ReqID, 2);
    @(negedge CLK); ServiceStart = 1'b1;
    @(negedge CLK); ServiceStart = 1'b0; DREQ = 4'b1111;
    repeat (2) @(negedge CLK);
    check("mid service busy", Busy, 1);
    MasterClear = 1'b1;
    after_edge();
    check("mclear valid", ValidReqID, 0);
    check("mclear busy", Busy, 0);
    @(negedge CLK); MasterClear = 1'b0;
    wait_grant("after mclear", 8);
    check("after mclear ptr zero", ReqID, 0);

    // Asynchronous reset between edges.
    serve();
    wait_grant("pre reset", 8);
    check("pre reset reqid", ReqID, 1);
    @(negedge CLK); ServiceStart = 1'b1;
    @(negedge CLK); ServiceStart = 1'b0;
    @(posedge CLK); #3; RESET_N = 1'b0;
    #1;
    check("async reset valid", ValidReqID, 0);
    check("async reset busy", Busy, 0);
    check("async reset reqid", ReqID, 0);
    check("async reset status", ReqStatus, 0);
    @(negedge CLK); RESET_N = 1'b1;
    wait_grant("after reset", 8);
    check("after reset ptr zero", ReqID, 0);

    // Randomized traffic; the compare process does the checking.
    RESET_N = 1'b0; DREQ = '0; RotatingPriority = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) DREQ[b] = ~DREQ[b];
      if ($urandom_range(31) == 0) MaskReg = 4'($urandom_range(15));
      if ($urandom_range(31) == 0) SoftReq = ($urandom_range(1) == 0) ? 4'b0000 : 4'($urandom_range(15));
      if ($urandom_range(63) == 0) RotatingPriority = ~RotatingPriority;
      if ($urandom_range(15) == 0) ControllerDisable = ($urandom_range(3) == 0);
      ServiceStart = ($urandom_range((ValidReqID && !Busy) ? 3 : 15) == 0);
      ServiceDone  = ($urandom_range(Busy ? 3 : 15) == 0);
      MasterClear  = ($urandom_range(199) == 0);
    end
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
